// File: rtl/dmem_responder_if.sv
// Data-port bundle between the MEM-stage initiator and the memory responder.
interface dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        busy;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the LC-3b MEM-stage data port.
// Accepts one read/write request at a time, answers it LATENCY cycles after
// acceptance with a single mem_resp pulse, and backs it with a word RAM.
module dmem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);
  localparam bit         ONE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_cnt, w_cnt_nxt;
  logic [AW-1:0]  r_idx, w_idx_nxt;
  logic [15:0]    r_wdata, w_wdata_nxt;
  logic [1:0]     r_be, w_be_nxt;
  logic           r_is_wr, w_is_wr_nxt;

  logic           r_resp;
  logic           r_busy;
  logic [15:0]    r_rdata;

  logic [15:0]    r_mem [DEPTH_WORDS];

  // Address bits above the word index and the byte-select bit are ignored.
  logic           w_unused_addr;
  assign w_unused_addr = ^{bus.mem_address[15:AW+1], bus.mem_address[0]};

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_wdata_nxt = r_wdata;
    w_be_nxt    = r_be;
    w_is_wr_nxt = r_is_wr;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          // A simultaneous read and write is handled as a write.
          w_idx_nxt   = bus.mem_address[AW:1];
          w_wdata_nxt = bus.mem_wdata;
          w_be_nxt    = bus.mem_byte_enable;
          w_is_wr_nxt = bus.mem_write;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = ONE_CYCLE ? ST_RESP : ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 16'h0000;
      r_be    <= 2'b00;
      r_is_wr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_wdata <= w_wdata_nxt;
      r_be    <= w_be_nxt;
      r_is_wr <= w_is_wr_nxt;
    end
  end

  // Registered outputs; read data is captured on entry to RESP and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 16'h0000;
    end else begin
      r_resp <= (w_state_nxt == ST_RESP);
      r_busy <= (w_state_nxt != ST_IDLE);
      if ((w_state_nxt == ST_RESP) && !w_is_wr_nxt) begin
        r_rdata <= r_mem[w_idx_nxt];
      end
    end
  end

  // Commit a write at the end of its RESP cycle, enabled bytes only.
  always_ff @(posedge clk) begin
    if ((r_state == ST_RESP) && r_is_wr) begin
      if (r_be[0]) begin
        r_mem[r_idx][7:0] <= r_wdata[7:0];
      end
      if (r_be[1]) begin
        r_mem[r_idx][15:8] <= r_wdata[15:8];
      end
    end
  end

  assign bus.mem_resp  = r_resp;
  assign bus.mem_rdata = r_rdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (LATENCY 2 and 1) share
// a clock and reset; drivers push expected responses, a negedge monitor pops.
module tb_dmem_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if ifc0 ();
  dmem_responder_if ifc1 ();

  dmem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1.slave));

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          run    = 1'b0;
  int          lat       [2] = '{2, 1};
  int          idle_edge [2] = '{0, 0};
  int          bfrom     [2] = '{-1, -1};
  int          bto       [2] = '{-2, -2};
  logic [15:0] last_rd   [2] = '{16'h0000, 16'h0000};
  logic [15:0] mm        [2][256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: actual=%h required=%h at cycle %0d", nm, d, act, req, cyc);
    end
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] be);
    if (d == 0) begin
      ifc0.mem_read = rd; ifc0.mem_write = wr; ifc0.mem_address = a;
      ifc0.mem_wdata = wd; ifc0.mem_byte_enable = be;
    end else begin
      ifc1.mem_read = rd; ifc1.mem_write = wr; ifc1.mem_address = a;
      ifc1.mem_wdata = wd; ifc1.mem_byte_enable = be;
    end
  endtask

  function automatic logic get_resp(input int d);
    return (d == 0) ? ifc0.mem_resp : ifc1.mem_resp;
  endfunction

  // Monitor body for one responder: busy window, resp timing/data, rdata hold.
  task automatic mon(input int d, input logic resp, input logic busy, input logic [15:0] rdata);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    chk("busy", d, {31'd0, busy}, {31'd0, (cyc >= bfrom[d]) && (cyc <= bto[d])});
    if (resp) begin
      if (qs == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp dut%0d: actual=1 required=0 at cycle %0d", d, cyc);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("resp_cycle", d, cyc, e.cyc);
        if (e.is_rd) begin
          last_rd[d] = e.data;
        end
      end
    end else if (qs != 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_resp dut%0d: actual=none required=cycle %0d", d, e.cyc);
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    chk("rdata", d, {16'd0, rdata}, {16'd0, last_rd[d]});
  endtask

  always @(negedge clk) begin
    if (run) begin
      mon(0, ifc0.mem_resp, ifc0.busy, ifc0.mem_rdata);
      mon(1, ifc1.mem_resp, ifc1.busy, ifc1.mem_rdata);
    end
  end

  // One complete transaction as the initiator sees it. Called #1 after a
  // rising edge. keep: leave the request asserted after resp (back-to-back).
  // scram: drop the request and change its fields right after acceptance.
  task automatic xact(input int d, input logic rd, input logic wr, input logic [15:0] a,
                      input logic [15:0] wd, input logic [1:0] be, input bit keep, input bit scram);
    int   acc;
    int   idx;
    exp_t e;
    bit   seen;
    drive(d, rd, wr, a, wd, be);
    acc = (cyc + 1 > idle_edge[d]) ? cyc + 1 : idle_edge[d];
    idle_edge[d] = acc + lat[d] + 1;
    idx = int'(a[15:1]) % 256;
    e.cyc   = acc + lat[d] - 1;
    e.is_rd = !wr;
    e.data  = mm[d][idx];
    if (wr) begin
      if (be[0]) mm[d][idx][7:0]  = wd[7:0];
      if (be[1]) mm[d][idx][15:8] = wd[15:8];
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    bfrom[d] = acc;
    bto[d]   = acc + lat[d] - 1;
    if (scram) begin
      while (cyc < acc) begin @(posedge clk); #1; end
      drive(d, 1'b0, 1'b0, a ^ 16'h00C0, ~wd, ~be);
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = get_resp(d);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL resp_timeout dut%0d: actual=no resp required=resp within 40 cycles", d);
    end
    if (!keep) drive(d, 1'b0, 1'b0, a, wd, be);
    @(posedge clk); #1;
  endtask

  task automatic rand_xacts(input int d, input int n, input int words);
    logic [15:0] a;
    int          op;
    bit          kp;
    bit          sc;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 3);
      a  = 16'($urandom);
      a[8:1] = 8'($urandom_range(0, words - 1));
      sc = ($urandom_range(0, 4) == 0);
      kp = !sc && (i != n - 1) && ($urandom_range(0, 2) == 0);
      xact(d, op != 2, op >= 2, a, 16'($urandom), 2'($urandom), kp, sc);
    end
  endtask

  initial begin
    int          acc;
    logic [15:0] a;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;
    @(posedge clk); #1;

    // Basic write then read, LATENCY 2.
    xact(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("rd_beef", 0, {16'd0, ifc0.mem_rdata}, {16'd0, 16'hBEEF});

    // Byte-enable merges.
    xact(0, 1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, 1'b0);
    xact(0, 1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("rd_ab34", 0, {16'd0, ifc0.mem_rdata}, {16'd0, 16'hAB34});
    xact(0, 1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 1'b0, 1'b0);
    xact(0, 1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("rd_abcd", 0, {16'd0, ifc0.mem_rdata}, {16'd0, 16'hABCD});

    // LDI: pointer read immediately followed by the indirect read.
    xact(0, 1'b0, 1'b1, 16'h0040, 16'h0080, 2'b11, 1'b0, 1'b0);
    xact(0, 1'b0, 1'b1, 16'h0080, 16'h5A5A, 2'b11, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b1, 1'b0);
    chk("ldi_ptr", 0, {16'd0, ifc0.mem_rdata}, {16'd0, 16'h0080});
    xact(0, 1'b1, 1'b0, 16'h0080, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("ldi_data", 0, {16'd0, ifc0.mem_rdata}, {16'd0, 16'h5A5A});

    // Inputs changed and request dropped after acceptance.
    xact(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a write: no resp, no commit.
    xact(0, 1'b0, 1'b1, 16'h0030, 16'h0000, 2'b11, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1, 16'h0030, 16'hFFFF, 2'b11);
    acc = (cyc + 1 > idle_edge[0]) ? cyc + 1 : idle_edge[0];
    while (cyc < acc) begin @(posedge clk); #1; end
    drive(0, 1'b0, 1'b0, 16'h0030, 16'hFFFF, 2'b11);
    bfrom[0] = -1; bto[0] = -2;
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 0, {31'd0, ifc0.busy}, 32'd0);
    chk("rst_resp", 0, {31'd0, ifc0.mem_resp}, 32'd0);
    chk("rst_rdata", 0, {16'd0, ifc0.mem_rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_edge[0] = 0; idle_edge[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    xact(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("rst_nocommit", 0, {16'd0, ifc0.mem_rdata}, 32'd0);

    // Read and write together behave as a write.
    xact(0, 1'b1, 1'b1, 16'h0032, 16'h7E57, 2'b11, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b0, 16'h0032, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("rw_as_write", 0, {16'd0, ifc0.mem_rdata}, {16'd0, 16'h7E57});

    // Random traffic on a pre-initialised window with aliased upper bits.
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      a[8:1] = 8'(i);
      xact(0, 1'b0, 1'b1, a, 16'($urandom), 2'b11, 1'b0, 1'b0);
    end
    rand_xacts(0, 40, 16);

    // LATENCY 1 instance: aliasing and one-cycle response.
    xact(1, 1'b0, 1'b1, 16'h0202, 16'hC0DE, 2'b11, 1'b0, 1'b0);
    xact(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0, 1'b0);
    chk("l1_alias", 1, {16'd0, ifc1.mem_rdata}, {16'd0, 16'hC0DE});
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      a[8:1] = 8'(i);
      xact(1, 1'b0, 1'b1, a, 16'($urandom), 2'b11, 1'b0, 1'b0);
    end
    rand_xacts(1, 25, 8);

    repeat (6) @(posedge clk);
    #1;
    chk("q0_drained", 0, q0.size(), 32'd0);
    chk("q1_drained", 1, q1.size(), 32'd0);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

endmodule
